// File: rtl/iir_sched_pkg.sv
// Shared types and helpers for the iir_rr_sched round-robin filter scheduler.
package iir_sched_pkg;

    localparam int DW_DEF = 16;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        CAPTURE,
        OUT
    } state_t;

    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after rr_ptr wins.
module rr_arbiter
    import iir_sched_pkg::*;
#(
    parameter  int N_CH = 4,
    localparam int CW   = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req,
    input  logic [CW-1:0]   rr_ptr,
    output logic [N_CH-1:0] grant,
    output logic [CW-1:0]   grant_idx,
    output logic            any_grant
);

    localparam int unsigned NU = N_CH;

    always_comb begin
        int unsigned w_idx;
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_idx     = 0;
        for (int unsigned i = 0; i < NU; i++) begin
            w_idx = int'(rr_ptr) + i;
            if (w_idx >= NU) w_idx = w_idx - NU;
            if (!any_grant && req[w_idx]) begin
                grant[w_idx] = 1'b1;
                grant_idx    = CW'(w_idx);
                any_grant    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iir_rr_sched.sv
// Round-robin scheduler sharing one IIR filter datapath between N_CH sources.
// Optional per-channel grant counters under IIR_RR_SCHED_STATS_EN.
module iir_rr_sched
    import iir_sched_pkg::*;
#(
    parameter  int N_CH     = 4,
    parameter  int DW       = DW_DEF,
    parameter  int FILT_LAT = 1,
    localparam int CW       = $clog2(N_CH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_CH-1:0]    req_valid,
    input  logic [N_CH*DW-1:0] req_data,
    output logic [N_CH-1:0]    req_ready,
    output logic               filt_data_en,
    output logic [DW-1:0]      filt_data,
    output logic [CW-1:0]      filt_ch,
    input  logic [DW-1:0]      filt_result,
    output logic               out_valid,
    output logic [DW-1:0]      out_data,
    output logic [CW-1:0]      out_ch,
    input  logic               out_ready,
    output logic               busy
`ifdef IIR_RR_SCHED_STATS_EN
    ,
    input  logic               stats_clr,
    output logic [N_CH*16-1:0] grant_cnt
`endif
);

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_ptr;
    logic [CW-1:0]   r_ch;
    logic [DW-1:0]   r_sample;
    logic [3:0]      r_lat_cnt;
    logic [DW-1:0]   r_out_data;
    logic [CW-1:0]   r_out_ch;
    logic [N_CH-1:0] w_grant;
    logic [CW-1:0]   w_grant_idx;
    logic            w_any;
    logic [DW-1:0]   w_sel_data;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req       (req_valid),
        .rr_ptr    (r_ptr),
        .grant     (w_grant),
        .grant_idx (w_grant_idx),
        .any_grant (w_any)
    );

    assign w_sel_data = req_data[int'(w_grant_idx)*DW +: DW];

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next = ISSUE;
            ISSUE:   w_next = WAIT;
            WAIT:    if (r_lat_cnt == '0) w_next = CAPTURE;
            CAPTURE: w_next = OUT;
            OUT:     if (out_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_ch       <= '0;
            r_sample   <= '0;
            r_lat_cnt  <= '0;
            r_out_data <= '0;
            r_out_ch   <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                IDLE: if (w_any) begin
                    r_sample <= w_sel_data;
                    r_ch     <= w_grant_idx;
                end
                ISSUE:   r_lat_cnt <= 4'(FILT_LAT - 1);
                WAIT:    if (r_lat_cnt != '0) r_lat_cnt <= r_lat_cnt - 4'd1;
                CAPTURE: begin
                    r_out_data <= filt_result;
                    r_out_ch   <= r_ch;
                end
                OUT:     if (out_ready) r_ptr <= CW'(rr_next(int'(r_ch), N_CH));
                default: ;
            endcase
        end
    end

    // Grant is only offered in IDLE, so OUT backpressure stalls all sources.
    assign req_ready    = (r_state == IDLE) ? w_grant : '0;
    assign filt_data_en = (r_state == ISSUE);
    assign filt_data    = (r_state == ISSUE) ? r_sample : '0;
    assign filt_ch      = r_ch;
    assign out_valid    = (r_state == OUT);
    assign out_data     = r_out_data;
    assign out_ch       = r_out_ch;
    assign busy         = (r_state != IDLE);

`ifdef IIR_RR_SCHED_STATS_EN
    logic [15:0] r_cnt [N_CH];

    always_ff @(posedge clk) begin
        if (rst || stats_clr) begin
            for (int unsigned k = 0; k < N_CH; k++) r_cnt[k] <= '0;
        end else begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                if (r_state == IDLE && w_grant[k] && r_cnt[k] != '1)
                    r_cnt[k] <= r_cnt[k] + 16'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int unsigned k = 0; k < N_CH; k++) grant_cnt[k*16 +: 16] = r_cnt[k];
    end
`endif

endmodule
